// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared types and defaults for the USB RX packet sequencer.
// RX_PID_CHECK_EN adds the PID state that validates the first payload byte.
package rx_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
  localparam int         MAX_BYTES_DEF = 64;
  localparam int         CNT_W_DEF     = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECV     = 3'd1,
    ST_DONE     = 3'd2,
    ST_ERR_WAIT = 3'd3
`ifdef RX_PID_CHECK_EN
    ,
    ST_PID      = 3'd4
`endif
  } state_t;

`ifdef RX_PID_CHECK_EN
  localparam state_t ST_AFTER_SYNC = ST_PID;
`else
  localparam state_t ST_AFTER_SYNC = ST_RECV;
`endif

  // A USB PID carries its own complement in the upper nibble.
  function automatic logic pid_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/rx_fifo_ctrl_if.sv
// Byte-decoder / rx_fifo side signals of the RX sequencer.
// master drives the decoded byte stream and FIFO status; slave is the sequencer.
interface rx_fifo_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic             eop;
  logic             bit_err;
  logic             full;
  logic             w_enable;
  logic [7:0]       w_data;
  logic             rcving;
  logic             r_error;
  logic             pkt_done;
  logic [CNT_W-1:0] byte_cnt;

  modport master (
    output byte_valid, rx_byte, eop, bit_err, full,
    input  w_enable, w_data, rcving, r_error, pkt_done, byte_cnt
  );

  modport slave (
    input  byte_valid, rx_byte, eop, bit_err, full,
    output w_enable, w_data, rcving, r_error, pkt_done, byte_cnt
  );
endinterface

// File: rtl/rx_fifo_ctrl_byte_cnt.sv
// Saturating payload byte counter with synchronous clear and terminal flag.
module rx_byte_cnt #(
  parameter int CNT_W = 7,
  parameter int MAX   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != MAX_C))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_C);
endmodule

// File: rtl/rx_fifo_ctrl.sv
// RX packet sequencer: checks SYNC, writes payload into rx_fifo, flags faults.
// Optional first-byte PID check is enabled with RX_PID_CHECK_EN.
//
// state       | meaning
// ST_IDLE     | waiting for SYNC
// ST_PID      | (RX_PID_CHECK_EN) first payload byte must be a valid PID
// ST_RECV     | writing payload bytes
// ST_DONE     | one-cycle clean end of packet
// ST_ERR_WAIT | packet faulted, discard until eop
module rx_fifo_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_BYTES = MAX_BYTES_DEF,
  parameter int         CNT_W     = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rx_fifo_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic       w_enable_q, w_enable_d;
  logic [7:0] w_data_q, w_data_d;
  logic       rcving_q, rcving_d;
  logic       r_error_q, r_error_d;
  logic       pkt_done_q, pkt_done_d;

  logic             accept;
  logic             err;
  logic             cnt_clr;
  logic             at_max;
  logic [CNT_W-1:0] cnt;

  rx_byte_cnt #(
    .CNT_W (CNT_W),
    .MAX   (MAX_BYTES)
  ) u_byte_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (accept),
    .cnt    (cnt),
    .at_max (at_max)
  );

  always_comb begin
    state_d   = state_q;
    r_error_d = r_error_q;
    w_data_d  = w_data_q;
    accept    = 1'b0;
    err       = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.byte_valid) begin
          if (bus.rx_byte == SYNC_BYTE) begin
            state_d   = ST_AFTER_SYNC;
            r_error_d = 1'b0;
            cnt_clr   = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (bus.bit_err) begin
          err = 1'b1;
        end else begin
          if (bus.byte_valid) begin
            if (bus.full || at_max) err = 1'b1;
            else                    accept = 1'b1;
          end
          // eop sees the count as it stands after this cycle's byte
          if (!err && bus.eop) begin
            if (accept || (cnt != '0)) state_d = ST_DONE;
            else                       err = 1'b1;
          end
        end
      end
`ifdef RX_PID_CHECK_EN
      ST_PID: begin
        if (bus.bit_err) begin
          err = 1'b1;
        end else if (bus.byte_valid) begin
          if (bus.full || !pid_ok(bus.rx_byte)) begin
            err = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = bus.eop ? ST_DONE : ST_RECV;
          end
        end else if (bus.eop) begin
          err = 1'b1;
        end
      end
`endif
      ST_DONE:     state_d = ST_IDLE;
      ST_ERR_WAIT: if (bus.eop) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (err) begin
      state_d   = ST_ERR_WAIT;
      r_error_d = 1'b1;
    end
    if (accept) w_data_d = bus.rx_byte;

    w_enable_d = accept;
    pkt_done_d = (state_d == ST_DONE);
    rcving_d   = (state_d == ST_RECV) || (state_d == ST_ERR_WAIT)
`ifdef RX_PID_CHECK_EN
                 || (state_d == ST_PID)
`endif
                 ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      w_enable_q <= 1'b0;
      w_data_q   <= 8'h00;
      rcving_q   <= 1'b0;
      r_error_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_enable_q <= w_enable_d;
      w_data_q   <= w_data_d;
      rcving_q   <= rcving_d;
      r_error_q  <= r_error_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign bus.w_enable = w_enable_q;
  assign bus.w_data   = w_data_q;
  assign bus.rcving   = rcving_q;
  assign bus.r_error  = r_error_q;
  assign bus.pkt_done = pkt_done_q;
  assign bus.byte_cnt = cnt;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Self-checking bench for rx_fifo_ctrl: expected FIFO writes are queued as
// bytes are driven and popped when w_enable is observed.
module tb_rx_fifo_ctrl;

`ifdef RX_PID_CHECK_EN
  localparam bit PID_EN = 1'b1;
`else
  localparam bit PID_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_fifo_ctrl_if #(.CNT_W(7)) bus ();

  rx_fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int n_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  // write monitor / scoreboard
  always @(negedge clk) begin
    if (bus.pkt_done === 1'b1) n_done++;
    if (bus.w_enable === 1'b1) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got data %02h required no write", bus.w_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (bus.w_data !== exp_b) begin
          errors++;
          $display("FAIL wr_data got %02h required %02h", bus.w_data, exp_b);
        end
      end
    end
  end

  task automatic step(input logic bv, input logic [7:0] b, input logic e, input logic be);
    bus.byte_valid = bv;
    bus.rx_byte    = b;
    bus.eop        = e;
    bus.bit_err    = be;
    @(negedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.eop        = 1'b0;
    bus.bit_err    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_wr);
    if (expect_wr) exp_q.push_back(b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic send_eop();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic rst_cycles(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst_cycles(2);
    checks++;
    if ({bus.w_enable, bus.rcving, bus.r_error, bus.pkt_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000", {bus.w_enable, bus.rcving, bus.r_error, bus.pkt_done});
    end
    checks++;
    if ({bus.w_data, bus.byte_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_data_cnt got %02h/%0d required 00/0", bus.w_data, bus.byte_cnt);
    end
    send_byte(8'h80, 0);
    send_byte(8'hC3, 1);
    checks++;
    if (bus.byte_cnt !== 7'd1 || bus.rcving !== 1'b1) begin
      errors++;
      $display("FAIL midrx_pre got cnt %0d rcving %b required 1/1", bus.byte_cnt, bus.rcving);
    end
    rst_cycles(1);
    checks++;
    if ({bus.w_enable, bus.rcving, bus.r_error, bus.pkt_done, bus.w_data, bus.byte_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL midrx_reset got we%b rc%b er%b pd%b d%02h c%0d required all 0",
               bus.w_enable, bus.rcving, bus.r_error, bus.pkt_done, bus.w_data, bus.byte_cnt);
    end
  endtask

  task automatic test_good_packet();
    int wr0 = n_wr;
    int dn0 = n_done;
    send_byte(8'h80, 0);
    checks++;
    if (bus.rcving !== 1'b1 || bus.r_error !== 1'b0 || bus.byte_cnt !== 7'd0) begin
      errors++;
      $display("FAIL good_sync got rc%b er%b c%0d required 1/0/0", bus.rcving, bus.r_error, bus.byte_cnt);
    end
    send_byte(8'hC3, 1);
    send_byte(8'h5F, 1);
    send_byte(8'h0F, 1);
    send_eop();
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.byte_cnt !== 7'd3 || bus.r_error !== 1'b0 || bus.rcving !== 1'b0) begin
      errors++;
      $display("FAIL good_done got pd%b c%0d er%b rc%b required 1/3/0/0",
               bus.pkt_done, bus.byte_cnt, bus.r_error, bus.rcving);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.pkt_done !== 1'b0 || bus.byte_cnt !== 7'd3) begin
      errors++;
      $display("FAIL good_after got pd%b c%0d required 0/3", bus.pkt_done, bus.byte_cnt);
    end
    checks++;
    if (n_wr - wr0 != 3 || n_done - dn0 != 1) begin
      errors++;
      $display("FAIL good_counts got wr %0d done %0d required 3/1", n_wr - wr0, n_done - dn0);
    end
  endtask

  task automatic test_bad_sync();
    int wr0 = n_wr;
    int dn0 = n_done;
    send_byte(8'h81, 0);
    checks++;
    if (bus.r_error !== 1'b1) begin
      errors++;
      $display("FAIL badsync_err got %b required 1", bus.r_error);
    end
    send_byte(8'h12, 0);
    send_eop();
    checks++;
    if (bus.r_error !== 1'b1 || bus.rcving !== 1'b0 || n_wr != wr0 || n_done != dn0) begin
      errors++;
      $display("FAIL badsync_end got er%b rc%b wr%0d pd%0d required 1/0/0/0",
               bus.r_error, bus.rcving, n_wr - wr0, n_done - dn0);
    end
    send_byte(8'h80, 0);
    checks++;
    if (bus.r_error !== 1'b0) begin
      errors++;
      $display("FAIL badsync_clear got %b required 0", bus.r_error);
    end
    send_byte(8'hAA, !PID_EN);
    send_eop();
    checks++;
    if (bus.r_error !== PID_EN || n_done - dn0 != (PID_EN ? 0 : 1) || n_wr - wr0 != (PID_EN ? 0 : 1)) begin
      errors++;
      $display("FAIL badsync_next got er%b pd%0d wr%0d required %b/%0d/%0d",
               bus.r_error, n_done - dn0, n_wr - wr0, PID_EN, PID_EN ? 0 : 1, PID_EN ? 0 : 1);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    int wr0 = n_wr;
    int dn0 = n_done;
    send_byte(8'h80, 0);
    send_byte(8'hC3, 1);
    send_byte(8'h22, 1);
    bus.full = 1'b1;
    send_byte(8'h33, 0);
    bus.full = 1'b0;
    checks++;
    if (bus.r_error !== 1'b1 || bus.rcving !== 1'b1 || n_wr - wr0 != 2) begin
      errors++;
      $display("FAIL overrun got er%b rc%b wr%0d required 1/1/2", bus.r_error, bus.rcving, n_wr - wr0);
    end
    send_byte(8'h44, 0);
    send_eop();
    checks++;
    if (bus.rcving !== 1'b0 || bus.r_error !== 1'b1 || n_wr - wr0 != 2 || n_done != dn0) begin
      errors++;
      $display("FAIL overrun_end got rc%b er%b wr%0d pd%0d required 0/1/2/0",
               bus.rcving, bus.r_error, n_wr - wr0, n_done - dn0);
    end
  endtask

  task automatic test_oversize();
    int wr0 = n_wr;
    send_byte(8'h80, 0);
    send_byte(8'hC3, 1);
    for (int i = 1; i < 64; i++) send_byte(8'(i), 1);
    checks++;
    if (bus.byte_cnt !== 7'd64 || bus.r_error !== 1'b0 || n_wr - wr0 != 64) begin
      errors++;
      $display("FAIL oversize_full got c%0d er%b wr%0d required 64/0/64", bus.byte_cnt, bus.r_error, n_wr - wr0);
    end
    send_byte(8'hEE, 0);
    checks++;
    if (bus.byte_cnt !== 7'd64 || bus.r_error !== 1'b1 || n_wr - wr0 != 64) begin
      errors++;
      $display("FAIL oversize_err got c%0d er%b wr%0d required 64/1/64", bus.byte_cnt, bus.r_error, n_wr - wr0);
    end
    send_eop();
    checks++;
    if (bus.rcving !== 1'b0) begin
      errors++;
      $display("FAIL oversize_end got rc%b required 0", bus.rcving);
    end
  endtask

  task automatic test_empty();
    int dn0 = n_done;
    send_byte(8'h80, 0);
    send_eop();
    checks++;
    if (bus.r_error !== 1'b1 || bus.rcving !== 1'b1 || n_done != dn0) begin
      errors++;
      $display("FAIL empty got er%b rc%b pd%0d required 1/1/0", bus.r_error, bus.rcving, n_done - dn0);
    end
    send_eop();
    checks++;
    if (bus.rcving !== 1'b0) begin
      errors++;
      $display("FAIL empty_end got rc%b required 0", bus.rcving);
    end
  endtask

  task automatic test_corner();
    int wr0 = n_wr;
    int dn0 = n_done;
    send_byte(8'h80, 0);
    send_byte(8'h5A, 1);
    exp_q.push_back(8'hA5);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (bus.pkt_done !== 1'b1 || bus.byte_cnt !== 7'd2 || n_wr - wr0 != 2 || n_done - dn0 != 1) begin
      errors++;
      $display("FAIL byte_eop got pd%b c%0d wr%0d required 1/2/2", bus.pkt_done, bus.byte_cnt, n_wr - wr0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    wr0 = n_wr;
    send_byte(8'h80, 0);
    send_byte(8'hC3, 1);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    checks++;
    if (bus.r_error !== 1'b1 || bus.rcving !== 1'b1 || bus.byte_cnt !== 7'd1 || n_wr - wr0 != 1) begin
      errors++;
      $display("FAIL bit_err got er%b rc%b c%0d wr%0d required 1/1/1/1",
               bus.r_error, bus.rcving, bus.byte_cnt, n_wr - wr0);
    end
    send_eop();
  endtask

`ifdef RX_PID_CHECK_EN
  task automatic test_pid();
    int wr0 = n_wr;
    send_byte(8'h80, 0);
    send_byte(8'h33, 0);
    checks++;
    if (bus.r_error !== 1'b1 || n_wr != wr0) begin
      errors++;
      $display("FAIL pid_bad got er%b wr%0d required 1/0", bus.r_error, n_wr - wr0);
    end
    send_eop();
  endtask
`endif

  initial begin
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.eop        = 1'b0;
    bus.bit_err    = 1'b0;
    bus.full       = 1'b0;
    @(negedge clk);
    #1;
    test_reset();
    test_good_packet();
    test_bad_sync();
    test_overrun();
    test_oversize();
    test_empty();
    test_corner();
`ifdef RX_PID_CHECK_EN
    test_pid();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
